// File: rtl/m_calc_ctrl.sv
// Operand/opcode sequencer in front of the calculator ALU: captures A, B and the
// opcode from a shared entry bus on button presses and registers the ALU result.
module m_calc_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OPS        = 12,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       enter_btn,
    input  logic       chain,
    input  logic       clear,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flag,
    output logic [7:0] result,
    output logic [3:0] flags,
    output logic       result_valid,
    output logic       err,
    output logic       timeout,
    output logic [2:0] state
);

    localparam logic [2:0] S_GET_A  = 3'd0;
    localparam logic [2:0] S_GET_B  = 3'd1;
    localparam logic [2:0] S_GET_OP = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_SHOW   = 3'd4;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    logic                   enter;
    logic                   tmo_hit;
    logic                   entry_st;

    // The synchroniser ignores clear so a press coinciding with clear is dropped, not replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            sync_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], enter_btn};
            sync_q <= sync[SYNC_STAGES-1];
        end
    end

    assign enter        = sync[SYNC_STAGES-1] & ~sync_q;
    assign entry_st     = (state == S_GET_B) || (state == S_GET_OP);
    assign result_valid = (state == S_SHOW);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            logic [CW-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt <= '0;
                else if (clear || enter || !entry_st || tmo_hit)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;
            end
            assign tmo_hit = entry_st && !enter && (cnt == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_GET_A;
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_sel <= 4'h0;
            result  <= 8'h00;
            flags   <= 4'h0;
            err     <= 1'b0;
            timeout <= 1'b0;
        end else if (clear) begin
            state   <= S_GET_A;
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_sel <= 4'h0;
            result  <= 8'h00;
            flags   <= 4'h0;
            err     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_GET_A: if (enter) begin
                    alu_a <= data_in;
                    err   <= 1'b0;
                    state <= S_GET_B;
                end
                S_GET_B: if (enter) begin
                    alu_b <= data_in;
                    state <= S_GET_OP;
                end else if (tmo_hit) begin
                    alu_a   <= 8'h00;
                    alu_b   <= 8'h00;
                    alu_sel <= 4'h0;
                    timeout <= 1'b1;
                    state   <= S_GET_A;
                end
                S_GET_OP: if (enter) begin
                    alu_sel <= data_in[3:0];
                    // 8-bit compare also flags any nonzero upper nibble
                    err     <= (data_in >= 8'(NUM_OPS));
                    state   <= S_EXEC;
                end else if (tmo_hit) begin
                    alu_a   <= 8'h00;
                    alu_b   <= 8'h00;
                    alu_sel <= 4'h0;
                    timeout <= 1'b1;
                    state   <= S_GET_A;
                end
                S_EXEC: begin
                    result <= err ? 8'h00 : alu_out;
                    flags  <= err ? 4'h0  : alu_flag;
                    state  <= S_SHOW;
                end
                S_SHOW: if (enter) begin
                    if (chain) begin
                        alu_a <= result;
                        state <= S_GET_B;
                    end else begin
                        state <= S_GET_A;
                    end
                end
                default: state <= S_GET_A;
            endcase
        end
    end

endmodule
